ysyx_23060208_ifu_fq: RTL and testbench
=======================================

# ysyx_23060208_ifu_fq

Parametrised instruction fetch unit with a decoupled fetch queue. It keeps the fetch PC and issues pipelined requests to instruction memory over a valid/ready request channel with an in-order response channel. Fetched instructions are buffered in an `FQ_DEPTH`-entry queue, and each entry is handed to the IDU as a {pc, inst, err} tuple over a valid/ready handshake. EXU redirects flush the queue and discard all in-flight responses; this block replaces the single-register IFU in the pipeline front end.

## Interface
- `DATA_WIDTH`, 32, width of PC, address and instruction.
- `RESET_PC`, 32'h8000_0000, first fetch address after reset.
- `FQ_DEPTH`, 4, fetch-queue entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2, maximum imem requests in flight; power of two, ≥1, ≤`FQ_DEPTH`.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset, synchronous, active-high.
- `redirect_valid` in 1 — EXU redirect (branch taken / trap).
- `redirect_pc` in DATA_WIDTH — redirect target; bits[1:0] ignored (treated as 00).
- `imem_req_valid` out 1 — fetch request.
- `imem_req_ready` in 1 — memory accepts request.
- `imem_req_addr` out DATA_WIDTH — word-aligned fetch address.
- `imem_resp_valid` in 1 — response beat; in request order; always accepted.
- `imem_resp_data` in DATA_WIDTH — instruction.
- `imem_resp_err` in 1 — access fault for this response.
- `out_valid` out 1 — IDU tuple valid.
- `out_ready` in 1 — IDU allowin.
- `out_pc` out DATA_WIDTH — PC of delivered instruction.
- `out_inst` out DATA_WIDTH — instruction.
- `out_err` out 1 — fetch fault flag.
- `fetch_pc` out DATA_WIDTH — current fetch PC (DPI/debug export).

## Operation
- **`fetch_pc` register:**
  - Reset value is `RESET_PC`.
  - Advances by +4 on each request handshake (`imem_req_valid && imem_req_ready`).
  - Loads `{redirect_pc[W-1:2],2'b00}` on redirect; redirect wins over handshake.
  - `imem_req_addr` = `fetch_pc`.
- **Counters:**
  - `outstanding` (0..MAX_OUTSTANDING) counts requests handshaken but not yet responded, including those to be dropped.
  - `fq_count` (0..FQ_DEPTH) is the number of queue entries.
  - `drop_cnt` is the number of upcoming responses to discard.
- **Credit:** `credit = (outstanding < MAX_OUTSTANDING) && (outstanding - drop_cnt + fq_count < FQ_DEPTH)`.
- **Request valid:** `imem_req_valid = !rst && credit && !redirect_valid`.
  - Valid may fall without a handshake only because of a redirect or a credit change caused by a redirect.
  - Address is stable while valid is held.
- **In-flight PC FIFO** (depth MAX_OUTSTANDING):
  - Pushes `fetch_pc` on request handshake.
  - Pops on every non-dropped response.
  - The popped PC is written into the queue together with `imem_resp_data` and `imem_resp_err`.
- **Drop:** a response arriving while `drop_cnt > 0` is discarded. It decrements `drop_cnt` and `outstanding`, pops nothing, and enqueues nothing.
- **Redirect cycle:**
  - Fetch queue and in-flight PC FIFO are flushed.
  - `drop_cnt <= outstanding - (imem_resp_valid ? 1 : 0)`; any response in the same cycle is itself discarded.
  - `fetch_pc <= target`.
- **Output:**
  - `out_valid = (fq_count != 0) && !redirect_valid`.
  - `out_*` come from the queue head.
  - Pop on `out_valid && out_ready`.
- **Queue overflow:** impossible by credit. A response with no credit-backed slot is a protocol error; add an assertion.

## Timing
- Reset values: `imem_req_valid`=0 while `rst`; `out_valid`=0; `fetch_pc`=`RESET_PC`; all counters 0; queue empty.
- First request is asserted in the first cycle after `rst` falls.
- Response accepted in cycle N → `out_valid` in N+1. The queue is registered with no bypass, so an empty queue never pops.
- Simultaneous push and pop: both take effect; `fq_count` is unchanged. Pointers wrap modulo `FQ_DEPTH`.
- Queue full and `out_ready`=0: `credit`=0, so no new requests; already-outstanding responses still fit by construction.
- Redirect: `imem_req_valid`=0 and `out_valid`=0 in the redirect cycle. A request to the target may issue in the next cycle. The first target instruction appears 1 cycle after its response arrives.
- Back-to-back redirects: each reloads `drop_cnt` from the live `outstanding`.
- `rst` mid-operation: all state returns to reset values next cycle. Stale memory responses are the memory's responsibility; it is reset together with this block.

## Structure
- Shared package / `ysyx_23060208_npc.h` holds:
  - `RESET_PC` default.
  - `IFU_TO_IDU_BUS` width = 2*DATA_WIDTH+1.
  - `EXU_TO_IFU_BUS` width = DATA_WIDTH+1 ({taken, pc}); the top level maps taken→`redirect_valid`.
- Sub-module `ysyx_23060208_sync_fifo` (parameters: `WIDTH`, `DEPTH`; ports: `push`, `pop`, `flush`, `full`, `empty`, `count`). It is instantiated twice: fetch queue and in-flight PC FIFO.

## Test plan
- **Reset then free run, memory latency 1, `out_ready`=1:** `out_pc` sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, …; one instruction per cycle in steady state.
- **Backpressure:** `out_ready`=0 for 20 cycles → exactly 4 entries queued, `imem_req_valid`=0, no response lost; release → PCs continue in order without gaps.
- **Redirect with 2 outstanding to 0x8000_0100:** both stale responses dropped; next `out_pc`=0x8000_0100; queue contents before the redirect never appear.
- **Redirect in the same cycle as a response and an output handshake:** that response is discarded; `out_valid`=0 that cycle; `drop_cnt`=outstanding-1.
- **`imem_resp_err`=1 on the fetch at 0x8000_000C:** delivered tuple has `out_err`=1, `out_pc`=0x8000_000C; following fetches are unaffected.
- **Random `imem_req_ready`/latency/`out_ready`/redirects, scoreboarded against a reference PC model:** no overflow assertion; every delivered pc/inst pair matches memory.

Source files
------------

// File: rtl/ysyx_23060208_ifu_fq_pkg.sv
// Shared front-end constants for the fetch unit and its neighbours.
package ysyx_23060208_ifu_fq_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h8000_0000;

    // IFU -> IDU tuple {pc, inst, err}.
    localparam int unsigned IFU_TO_IDU_BUS = 2 * DATA_WIDTH_DEFAULT + 1;
    // EXU -> IFU redirect {taken, pc}; taken becomes redirect_valid.
    localparam int unsigned EXU_TO_IFU_BUS = DATA_WIDTH_DEFAULT + 1;

    // Width of one fetch-queue entry for a given datapath width.
    function automatic int unsigned ifu_to_idu_width(input int unsigned dw);
        return 2 * dw + 1;
    endfunction

endpackage

// File: rtl/ysyx_23060208_sync_fifo.sv
// Synchronous FIFO with flush; registered read data, no bypass.
module ysyx_23060208_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next pointers, occupancy and storage; flush empties the FIFO outright.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty so it has no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ysyx_23060208_ifu_fq.sv
// Instruction fetch unit with pipelined imem requests and a decoupled fetch
// queue feeding the IDU. Redirects flush everything and drop stale responses.
module ysyx_23060208_ifu_fq
    import ysyx_23060208_ifu_fq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned FQ_DEPTH = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  out_err,
    output logic [DATA_WIDTH-1:0] fetch_pc
);

    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FCW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned SW  = $clog2(FQ_DEPTH + MAX_OUTSTANDING + 1) + 1;
    localparam int unsigned EW  = ifu_to_idu_width(DATA_WIDTH);

    // Handshake rule for both channels: a transfer happens exactly in a cycle
    // where valid && ready; request valid only drops without a transfer when a
    // redirect arrives, and the address is held stable while valid is high.

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]         outstanding_q, outstanding_d;
    logic [OW-1:0]         drop_cnt_q, drop_cnt_d;

    logic [SW-1:0]         slot_use;
    logic                  credit, req_fire, resp_drop, resp_keep, out_fire;

    logic [FCW-1:0]        fq_count;
    logic                  fq_full, fq_empty;
    logic [EW-1:0]         fq_rdata;

    logic [DATA_WIDTH-1:0] pc_rdata;
    logic [OW-1:0]         pc_count;
    logic                  pc_full, pc_empty;

    // Credit, handshakes and drop decision for the current cycle.
    always_comb begin
        // Live in-flight responses plus queued entries must leave a free slot.
        slot_use       = SW'(outstanding_q) - SW'(drop_cnt_q) + SW'(fq_count);
        credit         = (outstanding_q < OW'(MAX_OUTSTANDING)) && (slot_use < SW'(FQ_DEPTH));
        imem_req_valid = !rst && credit && !redirect_valid;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_drop      = imem_resp_valid && ((drop_cnt_q != '0) || redirect_valid);
        resp_keep      = imem_resp_valid && !resp_drop;
        out_valid      = !rst && !fq_empty && !redirect_valid;
        out_fire       = out_valid && out_ready;
    end

    // Next fetch PC and counters; a redirect overrides any handshake.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc & ~DATA_WIDTH'(3);
            outstanding_d = outstanding_q - OW'(imem_resp_valid);
            // Everything still in flight after this cycle is stale.
            drop_cnt_d    = outstanding_q - OW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
            end
            outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_resp_valid);
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - OW'(1);
            end
        end
    end

    // Fetch PC and in-flight bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign imem_req_addr = fetch_pc_q;
    assign fetch_pc      = fetch_pc_q;

    // PCs of live requests, matched in order against kept responses.
    ysyx_23060208_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .wdata (fetch_pc_q),
        .pop   (resp_keep),
        .flush (redirect_valid),
        .rdata (pc_rdata),
        .full  (pc_full),
        .empty (pc_empty),
        .count (pc_count)
    );

    // Fetch queue holding {pc, inst, err} tuples for the IDU.
    ysyx_23060208_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_keep),
        .wdata ({pc_rdata, imem_resp_data, imem_resp_err}),
        .pop   (out_fire),
        .flush (redirect_valid),
        .rdata (fq_rdata),
        .full  (fq_full),
        .empty (fq_empty),
        .count (fq_count)
    );

    assign {out_pc, out_inst, out_err} = fq_rdata;

    a_fq_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(resp_keep && fq_full));
    a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp_valid && (outstanding_q == '0)));
    a_pc_fifo_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(resp_keep && pc_empty));
    a_pc_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(req_fire && pc_full));
    a_pc_fifo_tracks_live: assert property (@(posedge clk) disable iff (rst)
        pc_count == (outstanding_q - drop_cnt_q));

endmodule

// File: tb/tb_ysyx_23060208_ifu_fq.sv
// Scoreboarded bench for the fetch unit: directed phases plus a random phase.
module tb_ysyx_23060208_ifu_fq;

    localparam int W = 32;
    localparam logic [W-1:0] RST_PC = 32'h8000_0000;
    localparam int STREAM_LEN = 512;

    logic         clk, rst;
    logic         redirect_valid;
    logic [W-1:0] redirect_pc;
    logic         imem_req_valid, imem_req_ready;
    logic [W-1:0] imem_req_addr;
    logic         imem_resp_valid;
    logic [W-1:0] imem_resp_data;
    logic         imem_resp_err;
    logic         out_valid, out_ready;
    logic [W-1:0] out_pc, out_inst;
    logic         out_err;
    logic [W-1:0] fetch_pc;

    int errors = 0;
    int checks = 0;

    logic [2*W:0] exp_q[$];
    logic [2*W:0] mon_e;

    logic [W-1:0] pend_addr[$];
    int           pend_due[$];
    int           cyc = 0;
    int           acc_cnt = 0;
    int           dlv_cnt = 0;
    int           mem_lat = 1;
    bit           rand_lat = 0;
    bit           rand_ready = 0;
    logic [W-1:0] err_pc = '1;
    bit           held = 0;
    logic [W-1:0] held_addr = '0;
    logic [W-1:0] resp_addr;
    int           d0, k;
    logic [W-1:0] tgt;

    ysyx_23060208_ifu_fq u_dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_err         (out_err),
        .fetch_pc        (fetch_pc)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction image: every word's content is a fixed scramble of its address.
    function automatic logic [W-1:0] mem_inst(input logic [W-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected delivery stream from a (word-aligned) start PC.
    task automatic expect_stream(input logic [W-1:0] base);
        logic [W-1:0] pc;
        exp_q.delete();
        for (int i = 0; i < STREAM_LEN; i++) begin
            pc = base + 32'(4 * i);
            exp_q.push_back({pc, mem_inst(pc), pc == err_pc});
        end
    endtask

    // Memory model: accepts at negedge, answers in order after its latency.
    initial begin
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                held = 0;
            end else begin
                if (held && imem_req_valid) begin
                    check("req_addr_stable", imem_req_addr, held_addr);
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend_addr.push_back(imem_req_addr);
                    pend_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 4)) : mem_lat));
                    acc_cnt++;
                    held = 0;
                end else begin
                    held      = imem_req_valid;
                    held_addr = imem_req_addr;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                resp_addr       = pend_addr.pop_front();
                void'(pend_due.pop_front());
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_inst(resp_addr);
                imem_resp_err   = (resp_addr == err_pc);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
                imem_resp_err   = 1'b0;
            end
            imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares every IDU handshake against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && redirect_valid) begin
                check("redirect_out_valid", 32'(out_valid), 0);
                check("redirect_req_valid", 32'(imem_req_valid), 0);
            end
            if (out_valid && out_ready) begin
                dlv_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got pc %h expected no delivery", out_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_pc", out_pc, mon_e[2*W:W+1]);
                    check("out_inst", out_inst, mon_e[W:1]);
                    check("out_err", 32'(out_err), 32'(mon_e[0]));
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check("rst_fetch_pc", fetch_pc, RST_PC);
        rst = 1'b0;
        expect_stream(RST_PC);
        @(negedge clk);
        check("first_req_valid", 32'(imem_req_valid), 1);
        check("first_req_addr", imem_req_addr, RST_PC);
    endtask

    // Wait for n more deliveries; leaves the caller at posedge + 1.
    task automatic wait_dlv(input int n, input int budget, input string name);
        int target;
        int cnt;
        target = dlv_cnt + n;
        cnt    = 0;
        while (dlv_cnt < target && cnt < budget) begin
            @(posedge clk);
            cnt++;
        end
        checks++;
        if (dlv_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: delivered %0d required %0d", name, dlv_cnt, target);
        end
        #1;
    endtask

    // One-cycle redirect issued from the current point in the cycle.
    task automatic do_redirect(input logic [W-1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        expect_stream(target & ~32'h3);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;

        // Free run, latency 1, fault on the fetch at 0x8000_000C.
        err_pc  = RST_PC + 32'hC;
        mem_lat = 1;
        do_reset();
        wait_dlv(4, 50, "free_run");
        d0 = dlv_cnt;
        repeat (8) @(posedge clk);
        check("steady_throughput", 32'(dlv_cnt - d0), 8);
        #1;

        // Backpressure for 20 cycles, then release.
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp_req_valid", 32'(imem_req_valid), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_queued", 32'(acc_cnt - dlv_cnt), 4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_dlv(10, 60, "bp_release");

        // Redirect with two requests outstanding and no response that cycle.
        err_pc  = '1;
        mem_lat = 3;
        do_reset();
        wait_dlv(3, 60, "lat3_start");
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (!(pend_addr.size() == 2 && !imem_resp_valid) && k < 50);
        check("lat3_window", 32'(pend_addr.size()), 2);
        do_redirect(32'h8000_0100);
        wait_dlv(6, 100, "redirect_two_out");

        // Redirect coinciding with a response and a pending output handshake.
        mem_lat   = 2;
        out_ready = 1'b0;
        do_reset();
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (!(imem_resp_valid && out_valid && pend_addr.size() == 1) && k < 50);
        check("same_cycle_out_valid_before", 32'(out_valid), 1);
        out_ready = 1'b1;
        do_redirect(32'h8000_0200);
        wait_dlv(4, 80, "redirect_same_cycle");

        // Back-to-back redirects; the second target has junk low bits.
        do_redirect(32'h8000_0300);
        do_redirect(32'h8000_0402);
        wait_dlv(5, 80, "redirect_back_to_back");

        // Random ready, latency, backpressure and redirects.
        err_pc     = RST_PC + 32'h20;
        rand_lat   = 1;
        rand_ready = 1;
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3000; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0 || (i % 200) == 199) begin
                tgt            = RST_PC + 32'($urandom_range(0, 1023));
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                expect_stream(tgt & ~32'h3);
            end else begin
                redirect_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        rand_ready     = 0;
        wait_dlv(4, 100, "random_tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
